// File: rtl/dmem_lsu.sv
// Load/store initiator between the memory-stage request channel and the data memory port.
// Single outstanding request: validate, issue one access, then hold the response until consumed.
module dmem_lsu #(
    parameter int unsigned ADDR_LIMIT  = 32768,
    parameter bit          CHECK_ALIGN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [0:1]  req_size,
    input  logic        req_signed,
    input  logic [0:31] req_addr,
    input  logic [0:31] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [0:31] resp_data,
    output logic        resp_fault,
    output logic [0:31] mem_addr,
    output logic [0:31] mem_wData,
    output logic        mem_writeEnable,
    output logic [0:1]  mem_dsize,
    input  logic [0:31] mem_rData
);

    localparam int unsigned DW = 32;
    localparam int unsigned SW = 2;
    localparam int unsigned EW = DW + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic          req_ready_q, req_ready_d;
    logic          resp_valid_q, resp_valid_d;
    logic          resp_fault_q, resp_fault_d;
    logic [0:DW-1] resp_data_q, resp_data_d;
    logic [0:DW-1] mem_addr_q, mem_addr_d;
    logic [0:DW-1] mem_wdata_q, mem_wdata_d;
    logic          mem_we_q, mem_we_d;
    logic [0:SW-1] mem_dsize_q, mem_dsize_d;
    logic          write_q, write_d;
    logic          signed_q, signed_d;

    logic [EW-1:0] req_end_c;
    logic          misalign_c;
    logic          req_fault_c;
    logic [0:DW-1] load_ext_c;

    // End address computed one bit wider so requests near the top of the address space cannot wrap.
    assign req_end_c = EW'(req_addr) + EW'(req_size) + EW'(1);

    assign misalign_c = CHECK_ALIGN &&
                        (((req_size == 2'd1) && req_addr[31]) ||
                         ((req_size == 2'd3) && (req_addr[30:31] != 2'b00)));

    assign req_fault_c = (req_size == 2'd2) || misalign_c || (req_end_c > EW'(ADDR_LIMIT));

    // Right-justify and extend the returned data; the first byte at the address sits in rData[0:7].
    always_comb begin
        load_ext_c = mem_rData;
        case (mem_dsize_q)
            2'd0:    load_ext_c = {{24{signed_q & mem_rData[0]}}, mem_rData[0:7]};
            2'd1:    load_ext_c = {{16{signed_q & mem_rData[0]}}, mem_rData[0:15]};
            default: load_ext_c = mem_rData;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_fault_d = resp_fault_q;
        resp_data_d  = resp_data_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_dsize_d  = mem_dsize_q;
        mem_we_d     = 1'b0;
        write_d      = write_q;
        signed_d     = signed_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    req_ready_d = 1'b0;
                    if (req_fault_c) begin
                        resp_valid_d = 1'b1;
                        resp_fault_d = 1'b1;
                        resp_data_d  = '0;
                        state_d      = S_RESP;
                    end else begin
                        // Memory-side registers only move for legal requests.
                        mem_addr_d  = req_addr;
                        mem_wdata_d = req_wdata;
                        mem_dsize_d = req_size;
                        mem_we_d    = req_write;
                        write_d     = req_write;
                        signed_d    = req_signed;
                        state_d     = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                resp_valid_d = 1'b1;
                resp_fault_d = 1'b0;
                resp_data_d  = write_q ? '0 : load_ext_c;
                state_d      = S_RESP;
            end
            S_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                resp_valid_d = 1'b0;
                resp_fault_d = 1'b0;
                req_ready_d  = 1'b1;
                state_d      = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_fault_q <= 1'b0;
            resp_data_q  <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_dsize_q  <= '0;
            mem_we_q     <= 1'b0;
            write_q      <= 1'b0;
            signed_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_fault_q <= resp_fault_d;
            resp_data_q  <= resp_data_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_dsize_q  <= mem_dsize_d;
            mem_we_q     <= mem_we_d;
            write_q      <= write_d;
            signed_q     <= signed_d;
        end
    end

    assign req_ready       = req_ready_q;
    assign resp_valid      = resp_valid_q;
    assign resp_fault      = resp_fault_q;
    assign resp_data       = resp_data_q;
    assign mem_addr        = mem_addr_q;
    assign mem_wData       = mem_wdata_q;
    assign mem_dsize       = mem_dsize_q;
    assign mem_writeEnable = mem_we_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: byte-array memory model plus a shadow reference memory and arithmetic predictor.
module tb_dmem_lsu;

    localparam int unsigned ADDR_LIMIT  = 32768;
    localparam bit          CHECK_ALIGN = 1'b1;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [0:1]  req_size;
    logic [0:31] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_fault;
    logic [0:31] resp_data;
    logic [0:31] mem_addr, mem_wData, mem_rData;
    logic        mem_writeEnable;
    logic [0:1]  mem_dsize;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem     [0:ADDR_LIMIT-1];
    logic [7:0] ref_mem [0:ADDR_LIMIT-1];

    logic [0:31] obs_data, obs_maddr, obs_mwdata;
    logic        obs_fault;
    logic [0:1]  obs_mdsize;
    int          obs_lat, obs_we;

    dmem_lsu #(.ADDR_LIMIT(ADDR_LIMIT), .CHECK_ALIGN(CHECK_ALIGN)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_fault(resp_fault), .mem_addr(mem_addr),
        .mem_wData(mem_wData), .mem_writeEnable(mem_writeEnable),
        .mem_dsize(mem_dsize), .mem_rData(mem_rData)
    );

    always #5 clk = ~clk;

    function automatic int midx(input logic [0:31] a, input int k);
        return int'((a + 32'(k)) & 32'(ADDR_LIMIT - 1));
    endfunction

    assign mem_rData = {mem[midx(mem_addr, 0)], mem[midx(mem_addr, 1)],
                        mem[midx(mem_addr, 2)], mem[midx(mem_addr, 3)]};

    always @(posedge clk) begin
        if (mem_writeEnable) begin
            case (mem_dsize)
                2'd0: mem[midx(mem_addr, 0)] <= mem_wData[24:31];
                2'd1: begin
                    mem[midx(mem_addr, 0)] <= mem_wData[16:23];
                    mem[midx(mem_addr, 1)] <= mem_wData[24:31];
                end
                default: begin
                    mem[midx(mem_addr, 0)] <= mem_wData[0:7];
                    mem[midx(mem_addr, 1)] <= mem_wData[8:15];
                    mem[midx(mem_addr, 2)] <= mem_wData[16:23];
                    mem[midx(mem_addr, 3)] <= mem_wData[24:31];
                end
            endcase
        end
    end

    // Reference rules: n = size+1 bytes, legal if naturally aligned and addr+n fits below the limit.
    function automatic logic predict_fault(input logic [0:1] sz, input logic [0:31] a);
        longint unsigned n, ea;
        n  = longint'(sz) + 1;
        ea = {32'd0, a};
        if (sz == 2'd2) return 1'b1;
        if (CHECK_ALIGN && (ea % n) != 0) return 1'b1;
        return (ea + n) > longint'(ADDR_LIMIT);
    endfunction

    function automatic logic [0:31] predict_load(input logic [0:1] sz, input logic sg, input logic [0:31] a);
        longint v = 0;
        longint one = 1;
        int n = int'(sz) + 1;
        for (int i = 0; i < n; i++) v = v * 256 + longint'(ref_mem[int'(a) + i]);
        if (sg && n < 4 && v >= (one << (8 * n - 1))) v = v - (one << (8 * n));
        return 32'(v);
    endfunction

    task automatic ref_store(input logic [0:1] sz, input logic [0:31] a, input logic [0:31] wd);
        int n = int'(sz) + 1;
        for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = 8'((wd >> (8 * (n - 1 - i))) & 32'hFF);
    endtask

    task automatic poke(input int a, input logic [7:0] b);
        mem[a] <= b;
        ref_mem[a] = b;
    endtask

    task automatic issue_req(input logic w, input logic [0:1] sz, input logic sg,
                             input logic [0:31] a, input logic [0:31] wd);
        obs_lat = 0; obs_we = 0; obs_maddr = '0; obs_mwdata = '0; obs_mdsize = '0;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        req_addr = $urandom; req_wdata = $urandom; req_write = ~w;
        do begin
            @(negedge clk);
            obs_lat++;
            if (mem_writeEnable) begin
                obs_we++; obs_maddr = mem_addr; obs_mdsize = mem_dsize; obs_mwdata = mem_wData;
            end
        end while (!resp_valid && obs_lat < 20);
        checks++;
        if (resp_valid !== 1'b1) begin errors++; $display("FAIL resp_timeout addr=%h got resp_valid=%b exp 1", a, resp_valid); end
        obs_data = resp_data; obs_fault = resp_fault;
    endtask

    task automatic consume_resp();
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = '0; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready got %b exp 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got %b exp 0", resp_valid); end
        checks++; if (resp_fault !== 1'b0) begin errors++; $display("FAIL rst_resp_fault got %b exp 0", resp_fault); end
        checks++; if (resp_data !== 32'h0) begin errors++; $display("FAIL rst_resp_data got %h exp 0", resp_data); end
        checks++; if (mem_writeEnable !== 1'b0) begin errors++; $display("FAIL rst_we got %b exp 0", mem_writeEnable); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr got %h exp 0", mem_addr); end
        checks++; if (mem_wData !== 32'h0) begin errors++; $display("FAIL rst_mem_wdata got %h exp 0", mem_wData); end
        checks++; if (mem_dsize !== 2'd0) begin errors++; $display("FAIL rst_mem_dsize got %0d exp 0", mem_dsize); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL post_rst_idle got ready=%b valid=%b exp 1/0", req_ready, resp_valid); end
    endtask

    task automatic test_word();
        issue_req(1'b1, 2'd3, 1'b0, 32'h100, 32'hDEADBEEF);
        checks++; if (obs_we !== 1) begin errors++; $display("FAIL sw_strobe_cycles got %0d exp 1", obs_we); end
        checks++; if (obs_mdsize !== 2'd3) begin errors++; $display("FAIL sw_dsize got %0d exp 3", obs_mdsize); end
        checks++; if (obs_maddr !== 32'h100) begin errors++; $display("FAIL sw_addr got %h exp 100", obs_maddr); end
        checks++; if (obs_mwdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_wdata got %h exp deadbeef", obs_mwdata); end
        checks++; if (obs_fault !== 1'b0 || obs_data !== 32'h0) begin errors++; $display("FAIL sw_resp got fault=%b data=%h exp 0/0", obs_fault, obs_data); end
        checks++; if (obs_lat !== 2) begin errors++; $display("FAIL sw_latency got %0d exp 2", obs_lat); end
        ref_store(2'd3, 32'h100, 32'hDEADBEEF);
        consume_resp();
        issue_req(1'b0, 2'd3, 1'b0, 32'h100, 32'h0);
        checks++; if (obs_data !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data got %h exp deadbeef", obs_data); end
        checks++; if (obs_fault !== 1'b0 || obs_we !== 0) begin errors++; $display("FAIL lw_flags got fault=%b we=%0d exp 0/0", obs_fault, obs_we); end
        checks++; if (obs_lat !== 2) begin errors++; $display("FAIL lw_latency got %0d exp 2", obs_lat); end
        consume_resp();
    endtask

    task automatic test_extend();
        poke(32'h204, 8'h80);
        poke(32'h300, 8'hF0);
        poke(32'h301, 8'h0D);
        issue_req(1'b0, 2'd0, 1'b1, 32'h204, 32'h0);
        checks++; if (obs_data !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_signed got %h exp ffffff80", obs_data); end
        consume_resp();
        issue_req(1'b0, 2'd0, 1'b0, 32'h204, 32'h0);
        checks++; if (obs_data !== 32'h00000080) begin errors++; $display("FAIL lb_unsigned got %h exp 00000080", obs_data); end
        consume_resp();
        issue_req(1'b0, 2'd1, 1'b1, 32'h300, 32'h0);
        checks++; if (obs_data !== 32'hFFFFF00D) begin errors++; $display("FAIL lh_signed got %h exp fffff00d", obs_data); end
        consume_resp();
        issue_req(1'b0, 2'd1, 1'b0, 32'h300, 32'h0);
        checks++; if (obs_data !== 32'h0000F00D) begin errors++; $display("FAIL lh_unsigned got %h exp 0000f00d", obs_data); end
        consume_resp();
        issue_req(1'b1, 2'd1, 1'b0, 32'h302, 32'h00001234);
        checks++; if (obs_mwdata !== 32'h00001234 || obs_mdsize !== 2'd1 || obs_we !== 1) begin
            errors++; $display("FAIL sh_port got wdata=%h dsize=%0d we=%0d exp 00001234/1/1", obs_mwdata, obs_mdsize, obs_we);
        end
        ref_store(2'd1, 32'h302, 32'h00001234);
        consume_resp();
        issue_req(1'b0, 2'd1, 1'b0, 32'h302, 32'h0);
        checks++; if (obs_data !== 32'h00001234) begin errors++; $display("FAIL lh_after_sh got %h exp 00001234", obs_data); end
        consume_resp();
    endtask

    typedef struct { logic w; logic [0:1] sz; logic [0:31] a; logic f; } fcase_t;

    task automatic test_faults();
        fcase_t tbl[9];
        logic [0:31] exp;
        tbl[0] = '{1'b1, 2'd3, 32'h00000102, 1'b1};
        tbl[1] = '{1'b0, 2'd3, 32'h00007FFE, 1'b1};
        tbl[2] = '{1'b0, 2'd2, 32'h00000200, 1'b1};
        tbl[3] = '{1'b0, 2'd1, 32'h00007FFF, 1'b1};
        tbl[4] = '{1'b0, 2'd0, 32'h00007FFF, 1'b0};
        tbl[5] = '{1'b0, 2'd3, 32'h00007FFC, 1'b0};
        tbl[6] = '{1'b0, 2'd0, 32'hFFFFFFFF, 1'b1};
        tbl[7] = '{1'b0, 2'd3, 32'hFFFFFFFC, 1'b1};
        tbl[8] = '{1'b1, 2'd1, 32'h00007FFE, 1'b0};
        for (int i = 0; i < 9; i++) begin
            exp = (tbl[i].f || tbl[i].w) ? 32'h0 : predict_load(tbl[i].sz, 1'b1, tbl[i].a);
            issue_req(tbl[i].w, tbl[i].sz, 1'b1, tbl[i].a, 32'hCAFEF00D);
            checks++; if (obs_fault !== tbl[i].f) begin errors++; $display("FAIL fault_flag[%0d] got %b exp %b", i, obs_fault, tbl[i].f); end
            checks++; if (obs_data !== exp) begin errors++; $display("FAIL fault_data[%0d] got %h exp %h", i, obs_data, exp); end
            checks++; if (obs_lat !== (tbl[i].f ? 1 : 2)) begin errors++; $display("FAIL fault_lat[%0d] got %0d exp %0d", i, obs_lat, tbl[i].f ? 1 : 2); end
            checks++; if (obs_we !== ((tbl[i].w && !tbl[i].f) ? 1 : 0)) begin errors++; $display("FAIL fault_we[%0d] got %0d", i, obs_we); end
            if (tbl[i].w && !tbl[i].f) ref_store(tbl[i].sz, tbl[i].a, 32'hCAFEF00D);
            consume_resp();
        end
    endtask

    task automatic test_backpressure();
        logic [0:31] exp;
        logic [0:31] word40;
        exp = predict_load(2'd3, 1'b0, 32'h100);
        issue_req(1'b0, 2'd3, 1'b0, 32'h100, 32'h0);
        for (int c = 0; c < 5; c++) begin
            checks++; if (resp_valid !== 1'b1 || resp_data !== exp || req_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold[%0d] got valid=%b data=%h ready=%b exp 1/%h/0", c, resp_valid, resp_data, req_ready, exp);
            end
            if (c == 1) begin
                req_valid = 1'b1; req_write = 1'b1; req_size = 2'd3; req_addr = 32'h40; req_wdata = 32'h11111111;
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clk);
            checks++; if (mem_writeEnable !== 1'b0) begin errors++; $display("FAIL bp_no_strobe[%0d] got %b exp 0", c, mem_writeEnable); end
        end
        consume_resp();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1 || mem_writeEnable !== 1'b0) begin
                errors++; $display("FAIL bp_not_accepted[%0d] got valid=%b ready=%b we=%b exp 0/1/0", c, resp_valid, req_ready, mem_writeEnable);
            end
        end
        word40 = {mem[32'h40], mem[32'h41], mem[32'h42], mem[32'h43]};
        checks++; if (word40 !== predict_load(2'd3, 1'b0, 32'h40)) begin errors++; $display("FAIL bp_mem_untouched got %h exp %h", word40, predict_load(2'd3, 1'b0, 32'h40)); end
    endtask

    task automatic test_random();
        logic w, sg, pf;
        logic [0:1] sz;
        logic [0:31] a, wd, exp;
        int sel;
        for (int i = 0; i < 300; i++) begin
            w = 1'($urandom_range(0, 1)); sg = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3)); wd = $urandom;
            sel = $urandom_range(0, 9);
            if (sel < 8)       a = 32'h400 + 32'($urandom_range(0, 63));
            else if (sel == 8) a = 32'(ADDR_LIMIT - 8) + 32'($urandom_range(0, 7));
            else               a = $urandom;
            pf  = predict_fault(sz, a);
            exp = (pf || w) ? 32'h0 : predict_load(sz, sg, a);
            issue_req(w, sz, sg, a, wd);
            checks++; if (obs_fault !== pf) begin errors++; $display("FAIL rnd_fault[%0d] a=%h sz=%0d got %b exp %b", i, a, sz, obs_fault, pf); end
            checks++; if (obs_data !== exp) begin errors++; $display("FAIL rnd_data[%0d] a=%h sz=%0d got %h exp %h", i, a, sz, obs_data, exp); end
            checks++; if (obs_lat !== (pf ? 1 : 2) || obs_we !== ((w && !pf) ? 1 : 0)) begin
                errors++; $display("FAIL rnd_timing[%0d] got lat=%0d we=%0d exp %0d/%0d", i, obs_lat, obs_we, pf ? 1 : 2, (w && !pf) ? 1 : 0);
            end
            if (w && !pf) ref_store(sz, a, wd);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            checks++; if (resp_data !== exp) begin errors++; $display("FAIL rnd_hold[%0d] got %h exp %h", i, resp_data, exp); end
            consume_resp();
        end
    endtask

    task automatic test_reset_mid();
        logic [0:31] word;
        for (int i = 0; i < 4; i++) poke(32'h500 + i, 8'h00);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd3; req_signed = 1'b0; req_addr = 32'h500; req_wdata = 32'hA5A5A5A5;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        checks++; if (mem_writeEnable !== 1'b1) begin errors++; $display("FAIL rm_in_access got we=%b exp 1", mem_writeEnable); end
        #1 reset = 1'b1;
        #1;
        checks++; if (mem_writeEnable !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL rm_async got we=%b valid=%b ready=%b exp 0/0/1", mem_writeEnable, resp_valid, req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rm_idle got valid=%b ready=%b exp 0/1", resp_valid, req_ready); end
        word = {mem[32'h500], mem[32'h501], mem[32'h502], mem[32'h503]};
        checks++; if (word !== 32'h0) begin errors++; $display("FAIL rm_mem_unchanged got %h exp 0", word); end
        issue_req(1'b0, 2'd3, 1'b0, 32'h500, 32'h0);
        checks++; if (obs_data !== predict_load(2'd3, 1'b0, 32'h500)) begin errors++; $display("FAIL rm_reload got %h exp 0", obs_data); end
        consume_resp();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int diffs;
        for (int i = 0; i < int'(ADDR_LIMIT); i++) poke(i, 8'($urandom));
        test_reset();
        test_word();
        test_extend();
        test_faults();
        test_backpressure();
        test_random();
        test_reset_mid();
        @(negedge clk);
        diffs = 0;
        for (int i = 0; i < int'(ADDR_LIMIT); i++) if (mem[i] !== ref_mem[i]) diffs++;
        checks++; if (diffs !== 0) begin errors++; $display("FAIL mem_image got %0d differing bytes exp 0", diffs); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
